// File: rtl/xip_cache_pkg.sv
// Shared types and helpers for the APB XIP word cache.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package xip_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACC  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [31:0] FLASH_BASE_DEF = 32'h3000_0000;
  localparam logic [31:0] FLASH_END_DEF  = 32'h3fff_ffff;

  // True when addr falls inside the cacheable flash window (inclusive bounds).
  function automatic logic is_flash(input logic [31:0] addr,
                                    input logic [31:0] base = FLASH_BASE_DEF,
                                    input logic [31:0] last = FLASH_END_DEF);
    return (addr >= base) && (addr <= last);
  endfunction

endpackage

// File: rtl/xip_cache_array.sv
// Valid/tag/data storage for a direct-mapped one-word-per-line cache.
// Latency: combinational read port, write and valid clear take effect on the next edge.
// Backpressure: none; a write is accepted every cycle, a clear overrides a same-cycle write.
module xip_cache_array #(
  parameter int LINES = 16,
  parameter int IW    = $clog2(LINES),
  parameter int TW    = 26 - IW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] rd_idx_i,
  output logic          rd_vld_o,
  output logic [TW-1:0] rd_tag_o,
  output logic [31:0]   rd_dat_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [TW-1:0] wr_tag_i,
  input  logic [31:0]   wr_dat_i,
  input  logic          clr_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign rd_vld_o = valid_q[rd_idx_i];
  assign rd_tag_o = tag_q[rd_idx_i];
  assign rd_dat_o = data_q[rd_idx_i];

  // Next valid vector: a fill sets its line, a flush clears everything and wins.
  always_comb begin
    valid_d = valid_q;
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
    if (clr_i) begin
      valid_d = '0;
    end
  end

  // Valid bits are the only storage that must come out of reset clean.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data need no reset: they are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_dat_i;
    end
  end

endmodule

// File: rtl/apb_xip_cache.sv
// Read-only direct-mapped word cache between an APB master and the SPI flash APB slave.
// Latency: hits and flash writes answer in the access cycle; misses/pass-through take 3 cycles plus downstream waits.
// Backpressure: upstream stalled via in_pready while one downstream transfer is outstanding.
module apb_xip_cache
  import xip_cache_pkg::*;
#(
  parameter int          LINES      = 16,
  parameter logic [31:0] FLASH_BASE = FLASH_BASE_DEF,
  parameter logic [31:0] FLASH_END  = FLASH_END_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr,
  input  logic        flush
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 26 - IW;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [2:0]  prot_q, prot_d;
  logic        flash_q, flash_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;

  logic          access;
  logic          req_flash;
  logic          hit;
  logic          fill;
  logic          rd_vld;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_dat;

  assign access    = in_psel & in_penable;
  assign req_flash = is_flash(in_paddr, FLASH_BASE, FLASH_END);
  assign hit       = rd_vld && (rd_tag == in_paddr[27:IW+2]);

  xip_cache_array #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_idx_i (in_paddr[IW+1:2]),
    .rd_vld_o (rd_vld),
    .rd_tag_o (rd_tag),
    .rd_dat_o (rd_dat),
    .wr_en_i  (fill),
    .wr_idx_i (addr_q[IW+1:2]),
    .wr_tag_i (addr_q[27:IW+2]),
    .wr_dat_i (out_prdata),
    .clr_i    (flush)
  );

  // Downstream bus is driven straight from registers.
  assign out_paddr   = addr_q;
  assign out_pwrite  = write_q;
  assign out_pwdata  = wdata_q;
  assign out_pstrb   = strb_q;
  assign out_pprot   = prot_q;
  assign out_psel    = psel_q;
  assign out_penable = penable_q;

  // Next-state, upstream response mux and request latching.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prot_d     = prot_q;
    flash_d    = flash_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    in_pready  = 1'b0;
    in_prdata  = '0;
    in_pslverr = 1'b0;
    fill       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (req_flash && in_pwrite) begin
            // Flash is read-only here: refuse the write without touching the bus.
            in_pready  = 1'b1;
            in_pslverr = 1'b1;
          end else if (req_flash && hit) begin
            in_pready = 1'b1;
            in_prdata = rd_dat;
          end else begin
            // Flash misses always fetch the whole aligned word as a plain read.
            addr_d  = req_flash ? {in_paddr[31:2], 2'b00} : in_paddr;
            write_d = req_flash ? 1'b0 : in_pwrite;
            strb_d  = req_flash ? 4'h0 : in_pstrb;
            wdata_d = in_pwdata;
            prot_d  = in_pprot;
            flash_d = req_flash;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        state_d = ST_ACC;
      end
      ST_ACC: begin
        if (out_pready) begin
          rdata_d = out_prdata;
          err_d   = out_pslverr;
          fill    = flash_q & ~out_pslverr;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        in_pready  = 1'b1;
        in_prdata  = rdata_q;
        in_pslverr = err_q;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Select/enable follow the state being entered so they leave a register.
  always_comb begin
    psel_d    = (state_d == ST_REQ) || (state_d == ST_ACC);
    penable_d = (state_d == ST_ACC);
  end

  // State and latched transfer registers; reset drops any downstream transfer at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      flash_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      flash_q   <= flash_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

endmodule

// File: tb/tb_apb_xip_cache.sv
// Directed bench for apb_xip_cache with a simple downstream APB slave model.
// Latency: checks upstream ready position relative to the first access cycle.
// Backpressure: downstream wait states come from each vector.
module tb_apb_xip_cache;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] in_paddr;
  logic        in_psel;
  logic        in_penable;
  logic [2:0]  in_pprot;
  logic        in_pwrite;
  logic [31:0] in_pwdata;
  logic [3:0]  in_pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;
  logic        flush;
  logic        flush_up;
  logic        flush_dn;

  assign flush = flush_up | flush_dn;

  always #5 clock = ~clock;

  apb_xip_cache #(.LINES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_paddr    (in_paddr),
    .in_psel     (in_psel),
    .in_penable  (in_penable),
    .in_pprot    (in_pprot),
    .in_pwrite   (in_pwrite),
    .in_pwdata   (in_pwdata),
    .in_pstrb    (in_pstrb),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_pslverr  (in_pslverr),
    .out_paddr   (out_paddr),
    .out_psel    (out_psel),
    .out_penable (out_penable),
    .out_pprot   (out_pprot),
    .out_pwrite  (out_pwrite),
    .out_pwdata  (out_pwdata),
    .out_pstrb   (out_pstrb),
    .out_pready  (out_pready),
    .out_prdata  (out_prdata),
    .out_pslverr (out_pslverr),
    .flush       (flush)
  );

  int errors = 0;
  int checks = 0;

  // Downstream slave model state
  int          dn_wait = 0;
  int          wait_ctr = 0;
  int          dn_cnt = 0;
  logic [31:0] dn_rdata_v = '0;
  logic        dn_err_v = 1'b0;
  logic        flush_on_ready = 1'b0;
  logic [31:0] dn_addr_s = '0;
  logic        dn_wr_s = 1'b0;
  logic [3:0]  dn_strb_s = '0;
  logic [31:0] dn_wdata_s = '0;
  logic [2:0]  dn_prot_s = '0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] dn_rd;
    logic        dn_err;
    int          dn_wt;
    int          exp_lat;
    logic        chk_dat;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        fwd;
    logic [31:0] exp_da;
    logic        exp_dw;
    logic [3:0]  exp_ds;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Downstream slave: records each setup phase, answers after dn_wait ACC cycles.
  initial begin
    out_pready  = 1'b0;
    out_prdata  = '0;
    out_pslverr = 1'b0;
    flush_dn    = 1'b0;
    forever begin
      @(negedge clock);
      out_pready = 1'b0;
      flush_dn   = 1'b0;
      if (out_psel && !out_penable) begin
        dn_cnt++;
        dn_addr_s  = out_paddr;
        dn_wr_s    = out_pwrite;
        dn_strb_s  = out_pstrb;
        dn_wdata_s = out_pwdata;
        dn_prot_s  = out_pprot;
        wait_ctr   = 0;
      end else if (out_psel && out_penable) begin
        if (wait_ctr >= dn_wait) begin
          out_pready  = 1'b1;
          out_prdata  = dn_rdata_v;
          out_pslverr = dn_err_v;
          flush_dn    = flush_on_ready;
        end else begin
          wait_ctr++;
        end
      end
    end
  end

  // One upstream APB transfer; lat counts cycles from the first access cycle.
  task automatic apb_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic fl, output int lat, output logic [31:0] rd,
                          output logic er);
    bit done;
    done = 0;
    lat  = 99;
    rd   = '0;
    er   = 1'b0;
    @(posedge clock);
    #1;
    in_paddr   = a;
    in_pwrite  = w;
    in_pwdata  = wd;
    in_psel    = 1'b1;
    in_penable = 1'b0;
    @(posedge clock);
    #1;
    in_penable = 1'b1;
    flush_up   = fl;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (in_pready === 1'b1) begin
        done = 1;
        lat  = c;
        rd   = in_prdata;
        er   = in_pslverr;
      end
    end
    if (!done) begin
      $display("FAIL timeout: no in_pready for addr %h within 20 cycles", a);
    end
    @(posedge clock);
    #1;
    in_psel    = 1'b0;
    in_penable = 1'b0;
    flush_up   = 1'b0;
  endtask

  task automatic run_vec(input string tag, input vec_t v, input logic fl, input logic fr);
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          cnt0;
    dn_rdata_v     = v.dn_rd;
    dn_err_v       = v.dn_err;
    dn_wait        = v.dn_wt;
    flush_on_ready = fr;
    cnt0           = dn_cnt;
    apb_xfer(v.addr, v.wr, v.wdata, fl, lat, rd, er);
    flush_on_ready = 1'b0;
    chk({tag, " latency"}, lat, v.exp_lat);
    chk({tag, " pslverr"}, {31'b0, er}, {31'b0, v.exp_err});
    if (v.chk_dat) chk({tag, " prdata"}, rd, v.exp_rd);
    chk({tag, " downstream count"}, dn_cnt - cnt0, v.fwd ? 1 : 0);
    if (v.fwd) begin
      chk({tag, " out_paddr"}, dn_addr_s, v.exp_da);
      chk({tag, " out_pwrite"}, {31'b0, dn_wr_s}, {31'b0, v.exp_dw});
      chk({tag, " out_pstrb"}, {28'b0, dn_strb_s}, {28'b0, v.exp_ds});
      chk({tag, " out_pprot"}, {29'b0, dn_prot_s}, 32'd5);
      if (v.wr) chk({tag, " out_pwdata"}, dn_wdata_s, v.wdata);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // addr wr wdata dn_rd dn_err dn_wt exp_lat chk_dat exp_rd exp_err fwd exp_da exp_dw exp_ds
    vq.push_back('{32'h3000_0100, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 3, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h3000_0100, 1'b0, 4'h0});
    vq.push_back('{32'h3000_0100, 1'b0, 32'h0, 32'h0,         1'b0, 0, 0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0});
    vq.push_back('{32'h3000_0140, 1'b0, 32'h0, 32'h1111_1111, 1'b0, 0, 3, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h3000_0140, 1'b0, 4'h0});
    vq.push_back('{32'h3000_0100, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 3, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h3000_0100, 1'b0, 4'h0});
    vq.push_back('{32'h3000_0140, 1'b0, 32'h0, 32'h2222_2222, 1'b0, 0, 3, 1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h3000_0140, 1'b0, 4'h0});
    vq.push_back('{32'h3000_0306, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 0, 3, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 32'h3000_0304, 1'b0, 4'h0});
    vq.push_back('{32'h3000_0304, 1'b0, 32'h0, 32'h0,         1'b0, 0, 0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0});
    vq.push_back('{32'h3000_0000, 1'b1, 32'h77,32'h0,         1'b0, 0, 0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 4'h0});
    vq.push_back('{32'h1000_1014, 1'b1, 32'h5, 32'h0,         1'b0, 0, 3, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1000_1014, 1'b1, 4'hF});
    vq.push_back('{32'h1000_1014, 1'b1, 32'h5, 32'h0,         1'b1, 1, 4, 1'b0, 32'h0,         1'b1, 1'b1, 32'h1000_1014, 1'b1, 4'hF});
    vq.push_back('{32'h2000_0008, 1'b0, 32'h0, 32'hAAAA_5555, 1'b0, 0, 3, 1'b1, 32'hAAAA_5555, 1'b0, 1'b1, 32'h2000_0008, 1'b0, 4'hF});
    vq.push_back('{32'h2000_0008, 1'b0, 32'h0, 32'h5555_AAAA, 1'b0, 0, 3, 1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 32'h2000_0008, 1'b0, 4'hF});
    vq.push_back('{32'h3000_0400, 1'b0, 32'h0, 32'hBAD0_BAD0, 1'b1, 0, 3, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h3000_0400, 1'b0, 4'h0});
    vq.push_back('{32'h3000_0400, 1'b0, 32'h0, 32'h600D_600D, 1'b0, 2, 5, 1'b1, 32'h600D_600D, 1'b0, 1'b1, 32'h3000_0400, 1'b0, 4'h0});
    vq.push_back('{32'h3000_0400, 1'b0, 32'h0, 32'h0,         1'b0, 0, 0, 1'b1, 32'h600D_600D, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0});
    vq.push_back('{32'h2FFF_FFFC, 1'b0, 32'h0, 32'h0F0F_0F0F, 1'b0, 0, 3, 1'b1, 32'h0F0F_0F0F, 1'b0, 1'b1, 32'h2FFF_FFFC, 1'b0, 4'hF});
    vq.push_back('{32'h3FFF_FFFC, 1'b0, 32'h0, 32'h3C3C_3C3C, 1'b0, 0, 3, 1'b1, 32'h3C3C_3C3C, 1'b0, 1'b1, 32'h3FFF_FFFC, 1'b0, 4'h0});
    vq.push_back('{32'h3FFF_FFFC, 1'b0, 32'h0, 32'h0,         1'b0, 0, 0, 1'b1, 32'h3C3C_3C3C, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0});
    vq.push_back('{32'h3FFF_FFFC, 1'b1, 32'h1, 32'h0,         1'b0, 0, 0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 4'h0});
    vq.push_back('{32'h4000_0000, 1'b1, 32'h9, 32'h0,         1'b0, 0, 3, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4000_0000, 1'b1, 4'hF});
    vq.push_back('{32'h3000_0304, 1'b0, 32'h0, 32'h0,         1'b0, 0, 0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,        1'b0, 4'h0});

    reset      = 1'b0;
    in_paddr   = '0;
    in_psel    = 1'b0;
    in_penable = 1'b0;
    in_pprot   = 3'b101;
    in_pwrite  = 1'b0;
    in_pwdata  = '0;
    in_pstrb   = 4'hF;
    flush_up   = 1'b0;

    repeat (3) @(negedge clock);
    chk("reset in_pready",   {31'b0, in_pready},   32'd0);
    chk("reset in_prdata",   in_prdata,            32'd0);
    chk("reset in_pslverr",  {31'b0, in_pslverr},  32'd0);
    chk("reset out_psel",    {31'b0, out_psel},    32'd0);
    chk("reset out_penable", {31'b0, out_penable}, 32'd0);
    chk("reset out_pwrite",  {31'b0, out_pwrite},  32'd0);
    chk("reset out_paddr",   out_paddr,            32'd0);
    chk("reset out_pwdata",  out_pwdata,           32'd0);
    chk("reset out_pstrb",   {28'b0, out_pstrb},   32'd0);
    chk("reset out_pprot",   {29'b0, out_pprot},   32'd0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      run_vec($sformatf("vec%0d", i), vq[i], 1'b0, 1'b0);
    end

    // Flush on the fill edge: the fill is discarded and every other line is dropped too.
    v = '{32'h3000_0200, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 3, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 32'h3000_0200, 1'b0, 4'h0};
    run_vec("flushfill miss", v, 1'b0, 1'b1);
    v = '{32'h3000_0200, 1'b0, 32'h0, 32'h1122_3344, 1'b0, 0, 3, 1'b1, 32'h1122_3344, 1'b0, 1'b1, 32'h3000_0200, 1'b0, 4'h0};
    run_vec("flushfill remiss", v, 1'b0, 1'b0);
    v = '{32'h3000_0200, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 32'h1122_3344, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0};
    run_vec("flushfill hit", v, 1'b0, 1'b0);
    v = '{32'h3000_0304, 1'b0, 32'h0, 32'h5566_7788, 1'b0, 0, 3, 1'b1, 32'h5566_7788, 1'b0, 1'b1, 32'h3000_0304, 1'b0, 4'h0};
    run_vec("flush cleared other", v, 1'b0, 1'b0);

    // Hit in the same cycle as a flush returns the old word, then the line is gone.
    v = '{32'h3000_0304, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 32'h5566_7788, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0};
    run_vec("hit during flush", v, 1'b1, 1'b0);
    v = '{32'h3000_0304, 1'b0, 32'h0, 32'h99AA_BBCC, 1'b0, 0, 3, 1'b1, 32'h99AA_BBCC, 1'b0, 1'b1, 32'h3000_0304, 1'b0, 4'h0};
    run_vec("after hit flush", v, 1'b0, 1'b0);

    // Reset while the downstream transfer is stalled in its access phase.
    dn_wait = 1000;
    @(posedge clock);
    #1;
    in_paddr   = 32'h3000_0500;
    in_pwrite  = 1'b0;
    in_psel    = 1'b1;
    in_penable = 1'b0;
    @(posedge clock);
    #1;
    in_penable = 1'b1;
    repeat (3) @(negedge clock);
    chk("midreset pre out_psel",    {31'b0, out_psel},    32'd1);
    chk("midreset pre out_penable", {31'b0, out_penable}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset out_psel",    {31'b0, out_psel},    32'd0);
    chk("midreset out_penable", {31'b0, out_penable}, 32'd0);
    chk("midreset in_pready",   {31'b0, in_pready},   32'd0);
    chk("midreset out_paddr",   out_paddr,            32'd0);
    in_psel    = 1'b0;
    in_penable = 1'b0;
    @(negedge clock);
    reset   = 1'b1;
    dn_wait = 0;
    v = '{32'h3FFF_FFFC, 1'b0, 32'h0, 32'h1357_9BDF, 1'b0, 0, 3, 1'b1, 32'h1357_9BDF, 1'b0, 1'b1, 32'h3FFF_FFFC, 1'b0, 4'h0};
    run_vec("post reset miss", v, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_xip_cache.md
# apb_xip_cache

Read-only, direct-mapped word cache on the APB path in front of `spi_top_apb`. It absorbs repeated XIP instruction/data fetches from the flash window 0x30000000–0x3fffffff. Each flash access that misses costs a full SPI command/address/data transfer; a hit completes with zero wait states. Accesses outside the flash window pass through unmodified. Flash writes are rejected with `pslverr`.

## Interface

Parameters:
- `LINES`, 16: number of one-word cache lines; power of two, 2..256.
- `FLASH_BASE`, 32'h30000000: first flash-window address.
- `FLASH_END`, 32'h3fffffff: last flash-window address.

Ports:
- `clock` in 1: sole clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted at 0).
- `in_paddr` in 32: upstream APB address.
- `in_psel` in 1: upstream select.
- `in_penable` in 1: upstream enable.
- `in_pprot` in 3: upstream protection; forwarded only.
- `in_pwrite` in 1: upstream write.
- `in_pwdata` in 32: upstream write data.
- `in_pstrb` in 4: upstream byte strobes.
- `in_pready` out 1: upstream ready.
- `in_prdata` out 32: upstream read data.
- `in_pslverr` out 1: upstream error.
- `out_paddr` out 32: downstream APB address, to `spi_top_apb`.
- `out_psel` out 1: downstream select.
- `out_penable` out 1: downstream enable.
- `out_pprot` out 3: downstream protection.
- `out_pwrite` out 1: downstream write.
- `out_pwdata` out 32: downstream write data.
- `out_pstrb` out 4: downstream strobes.
- `out_pready` in 1: downstream ready.
- `out_prdata` in 32: downstream read data.
- `out_pslverr` in 1: downstream error.
- `flush` in 1: single-cycle pulse; invalidates all lines.

## Operation

- Index is `in_paddr[IW+1:2]`, where IW = log2(LINES). Tag is `in_paddr[27:IW+2]`. Each line holds a valid bit, the tag and one 32-bit word. Byte offset is ignored; a full word is always cached.
- Flash access means FLASH_BASE ≤ `in_paddr` ≤ FLASH_END.
- FSM states: IDLE, REQ, ACC, RESP.
- IDLE, access phase (`in_psel & in_penable`):
  - Flash read, hit: `in_pready`=1 combinationally, `in_prdata`=line data, `in_pslverr`=0. Stay in IDLE.
  - Flash write: `in_pready`=1, `in_pslverr`=1. Nothing is forwarded. Stay in IDLE.
  - Flash read miss, or any non-flash access: latch addr/write/wdata/strb/prot, go to REQ.
- REQ: drive `out_psel`=1, `out_penable`=0, with the latched fields. Flash misses send the word-aligned address (`paddr & ~3`), `out_pwrite`=0 and `out_pstrb`=0. Next state is ACC.
- ACC: `out_psel`=1, `out_penable`=1. Hold until `out_pready`=1, then capture `out_prdata` and `out_pslverr` and go to RESP.
  - Flash miss with `out_pslverr`=0: write the line (valid=1, tag, data) on that same edge.
  - Flash miss with an error, or a non-flash access: no fill.
- RESP: `in_pready`=1, `in_prdata`=captured data, `in_pslverr`=captured error. Downstream is idle. Next state is IDLE.
- `flush`: clears every valid bit on the next edge. If `flush` coincides with a fill, the flush wins and the line ends invalid. A hit lookup in the same cycle as `flush` still returns the old data.
- Data is stored exactly as returned downstream; no byte reordering.

## Timing

- Reset (`reset`=0), applied asynchronously:
  - All valid bits are 0, FSM is IDLE.
  - `out_psel`, `out_penable`, `out_pwrite` are 0; `out_paddr`, `out_pwdata`, `out_pstrb`, `out_pprot` are 0.
  - `in_pready`=0, `in_prdata`=0, `in_pslverr`=0.
- Reset mid-transaction aborts the downstream transfer immediately. The upstream master sees no completion.
- Latencies are counted from the first upstream access-phase cycle, T:
  - Hit or flash write: ready at T (0 wait states).
  - Miss or pass-through: REQ at T+1, ACC at T+2, RESP at cycle D+1, where D is the cycle `out_pready`=1. With a zero-wait downstream this gives ready at T+3.
- Downstream outputs are registered. Upstream responses are combinational only for hits and flash writes.
- The upstream master must not change address or control while `in_pready`=0; this is APB-compliant.
- Only one downstream transaction is ever outstanding.

## Structure

- `xip_cache_pkg` holds:
  - the FSM state enum (IDLE/REQ/ACC/RESP);
  - the default flash-window constants;
  - the `is_flash(addr)` function.
- One sub-module, `xip_cache_array`: valid/tag/data storage with a combinational read port and a synchronous write port, plus a global valid clear.
- The FSM and APB muxing stay in `apb_xip_cache`.

## Test plan

- Read 0x30000100 after reset → downstream read at 0x30000100; returned 0xDEADBEEF appears with `in_pready` at T+3. Repeat the read → `in_pready` at T, data 0xDEADBEEF, no downstream activity.
- Read 0x30000100, then 0x30000140 (same index, LINES=16) → second is a miss and evicts the first. Reading 0x30000100 again → a miss.
- Read 0x30000102 → downstream address 0x30000100, and the line is filled. Reading 0x30000100 → hit.
- Write 0x30000000 → `in_pready`=1, `in_pslverr`=1 at T; `out_psel` stays 0.
- Write 0x10001014 with data 5 → forwarded with `out_pwrite`=1 and strb 0xF. Response mirrors `out_pslverr`; the cache is unchanged.
- Fill 0x30000200 while `flush` pulses on the `out_pready` cycle → the line ends invalid, and the next read of 0x30000200 misses. Downstream `out_pslverr`=1 on a miss → `in_pslverr`=1, no fill.
